// File: rtl/sciacc_pkg.sv
//------------------------------------------------------------------------------
// sciacc_pkg
//   Shared types and width helpers for the response-data RAM write scheduler.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sciacc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        CLOSE     = 2'd2,
        WAIT_SLOT = 2'd3
    } ram_wr_sched_state_e;

    localparam int RAM_WR_NUM_SLOTS_DEF  = 4;
    localparam int RAM_WR_SLOT_WORDS_DEF = 256;

    // Index width for a ring of n slots (never narrower than one bit).
    function automatic int slot_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a batch length of 0..w words inclusive.
    function automatic int len_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_wr_idle_timer.sv
//------------------------------------------------------------------------------
// ram_wr_idle_timer
//   Idle-cycle counter; o_expire flags the cycle the count reaches TIMEOUT_CYC-1.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_wr_idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_limit;

    assign w_at_limit = (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));
    assign o_expire   = i_count_en && !i_clear && w_at_limit;

    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_count_en) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_wr_batch_sched.sv
//------------------------------------------------------------------------------
// ram_wr_batch_sched
//   Ring-of-slots batch scheduler for the RAM write DMA; optional idle
//   auto-flush enabled by RAM_WR_SCHED_TIMEOUT_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_wr_batch_sched
    import sciacc_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int NUM_SLOTS      = RAM_WR_NUM_SLOTS_DEF,
    parameter int SLOT_WORDS     = RAM_WR_SLOT_WORDS_DEF
`ifdef RAM_WR_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC    = 1024
`endif
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_start,
    input  logic [RAM_ADDR_WIDTH-1:0]             cfg_base,
    input  logic                                  cfg_abort,
    input  logic                                  cfg_flush,
    input  logic                                  wr_done,
    input  logic                                  slot_release,
    output logic [RAM_ADDR_WIDTH-1:0]             base_addr,
    output logic                                  wr_allow,
    output logic                                  batch_done,
    output logic [slot_idx_width(NUM_SLOTS)-1:0]  done_slot,
    output logic [len_width(SLOT_WORDS)-1:0]      done_len,
    output logic [slot_idx_width(NUM_SLOTS):0]    occupancy,
    output logic                                  err
);

    localparam int c_slot_w = slot_idx_width(NUM_SLOTS);
    localparam int c_len_w  = len_width(SLOT_WORDS);
    localparam int c_occ_w  = c_slot_w + 1;
    localparam int c_off_w  = $clog2(SLOT_WORDS);

    ram_wr_sched_state_e         r_state, w_state;
    logic [RAM_ADDR_WIDTH-1:0]   r_region_base, w_region_base;
    logic [c_slot_w-1:0]         r_cur_slot, w_cur_slot;
    logic [c_len_w-1:0]          r_wr_cnt, w_wr_cnt;
    logic [c_len_w-1:0]          r_done_len, w_done_len;
    logic [c_occ_w-1:0]          r_occupancy, w_occupancy;
    logic                        r_err, w_err;
    logic                        w_rel_ok;
    logic                        w_err_evt;
    logic                        w_flush;
    logic                        w_timeout;

`ifdef RAM_WR_SCHED_TIMEOUT_EN
    ram_wr_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (wr_done),
        .i_count_en ((r_state == FILL) && (r_wr_cnt != '0)),
        .o_expire   (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign w_flush   = cfg_flush || w_timeout;
    assign w_rel_ok  = slot_release && (r_occupancy != '0);
    assign w_err_evt = (wr_done && (r_state != FILL)) ||
                       (slot_release && (r_occupancy == '0));

    always_comb begin
        w_state       = r_state;
        w_region_base = r_region_base;
        w_cur_slot    = r_cur_slot;
        w_wr_cnt      = r_wr_cnt;
        w_done_len    = r_done_len;
        w_occupancy   = w_rel_ok ? (r_occupancy - c_occ_w'(1)) : r_occupancy;
        w_err         = r_err || w_err_evt;

        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state       = FILL;
                    w_region_base = cfg_base;
                    w_cur_slot    = '0;
                    w_wr_cnt      = '0;
                    w_occupancy   = '0;
                    w_err         = 1'b0;
                end
            end
            FILL: begin
                if (wr_done && (r_wr_cnt == c_len_w'(SLOT_WORDS - 1))) begin
                    w_state    = CLOSE;
                    w_done_len = c_len_w'(SLOT_WORDS);
                    w_wr_cnt   = '0;
                end else if (w_flush && ((r_wr_cnt != '0) || wr_done)) begin
                    w_state    = CLOSE;
                    w_done_len = r_wr_cnt + c_len_w'(wr_done);
                    w_wr_cnt   = '0;
                end else if (wr_done) begin
                    w_wr_cnt   = r_wr_cnt + c_len_w'(1);
                end
            end
            CLOSE: begin
                // A release landing on the close cancels the increment.
                w_cur_slot  = r_cur_slot + c_slot_w'(1);
                w_wr_cnt    = '0;
                w_occupancy = w_rel_ok ? r_occupancy : (r_occupancy + c_occ_w'(1));
                w_state     = (w_occupancy == c_occ_w'(NUM_SLOTS)) ? WAIT_SLOT : FILL;
            end
            WAIT_SLOT: begin
                if (w_rel_ok) begin
                    w_state = FILL;
                end
            end
            default: w_state = IDLE;
        endcase

        if (cfg_abort) begin
            w_state     = IDLE;
            w_wr_cnt    = '0;
            w_occupancy = '0;
            w_err       = r_err || w_err_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_region_base <= '0;
            r_cur_slot    <= '0;
            r_wr_cnt      <= '0;
            r_done_len    <= '0;
            r_occupancy   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_region_base <= w_region_base;
            r_cur_slot    <= w_cur_slot;
            r_wr_cnt      <= w_wr_cnt;
            r_done_len    <= w_done_len;
            r_occupancy   <= w_occupancy;
            r_err         <= w_err;
        end
    end

    assign base_addr  = r_region_base + (RAM_ADDR_WIDTH'(r_cur_slot) << c_off_w);
    assign wr_allow   = (r_state == FILL);
    assign batch_done = (r_state == CLOSE);
    assign done_slot  = batch_done ? r_cur_slot : '0;
    assign done_len   = batch_done ? r_done_len : '0;
    assign occupancy  = r_occupancy;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_batch_sched.sv
//------------------------------------------------------------------------------
// tb_ram_wr_batch_sched
//   Directed self-checking bench: 4 slots of 8 words, 16-bit addresses.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_wr_batch_sched;

    logic        clk = 1'b0;
    logic        reset, cfg_start, cfg_abort, cfg_flush, wr_done, slot_release;
    logic [15:0] cfg_base, base_addr;
    logic        wr_allow, batch_done, err;
    logic [1:0]  done_slot;
    logic [3:0]  done_len;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_wr_batch_sched #(
        .RAM_ADDR_WIDTH (16),
        .NUM_SLOTS      (4),
        .SLOT_WORDS     (8)
`ifdef RAM_WR_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC    (16)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_base     (cfg_base),
        .cfg_abort    (cfg_abort),
        .cfg_flush    (cfg_flush),
        .wr_done      (wr_done),
        .slot_release (slot_release),
        .base_addr    (base_addr),
        .wr_allow     (wr_allow),
        .batch_done   (batch_done),
        .done_slot    (done_slot),
        .done_len     (done_len),
        .occupancy    (occupancy),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_done = 1'b1;
            tick();
        end
        wr_done = 1'b0;
    endtask

    task automatic start(input logic [15:0] b);
        cfg_base  = b;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic abort();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    task automatic release_one();
        slot_release = 1'b1;
        tick();
        slot_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_flush = 1'b0;
        wr_done = 1'b0; slot_release = 1'b0; cfg_base = 16'h0;
        tick(); tick();
        n_cmp++; if (base_addr !== 16'h0) begin n_bad++; $display("FAIL reset_base: got %h want 0000", base_addr); end
        n_cmp++; if (wr_allow !== 1'b0) begin n_bad++; $display("FAIL reset_allow: got %b want 0", wr_allow); end
        n_cmp++; if (batch_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", batch_done); end
        n_cmp++; if ({done_slot, done_len} !== 6'h0) begin n_bad++; $display("FAIL reset_slot_len: got %h/%h want 0/0", done_slot, done_len); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        start(16'h0100);
        n_cmp++; if (wr_allow !== 1'b1) begin n_bad++; $display("FAIL fill_allow: got %b want 1", wr_allow); end
        n_cmp++; if (base_addr !== 16'h0100) begin n_bad++; $display("FAIL fill_base0: got %h want 0100", base_addr); end
        write_words(7);
        n_cmp++; if (batch_done !== 1'b0) begin n_bad++; $display("FAIL fill_early_done: got %b want 0", batch_done); end
        write_words(1);
        n_cmp++; if (batch_done !== 1'b1) begin n_bad++; $display("FAIL fill_done: got %b want 1", batch_done); end
        n_cmp++; if (done_slot !== 2'd0 || done_len !== 4'd8) begin n_bad++; $display("FAIL fill_slot_len: got %0d/%0d want 0/8", done_slot, done_len); end
        n_cmp++; if (wr_allow !== 1'b0) begin n_bad++; $display("FAIL fill_close_allow: got %b want 0", wr_allow); end
        tick();
        n_cmp++; if (base_addr !== 16'h0108) begin n_bad++; $display("FAIL fill_base1: got %h want 0108", base_addr); end
        n_cmp++; if (occupancy !== 3'd1 || wr_allow !== 1'b1 || batch_done !== 1'b0) begin n_bad++; $display("FAIL fill_after: got occ=%0d allow=%b done=%b want 1/1/0", occupancy, wr_allow, batch_done); end
    endtask

    task automatic test_stall();
        for (int s = 1; s < 4; s++) begin
            write_words(8);
            n_cmp++; if (batch_done !== 1'b1 || done_slot !== 2'(s)) begin n_bad++; $display("FAIL stall_close%0d: got done=%b slot=%0d want 1/%0d", s, batch_done, done_slot, s); end
            tick();
        end
        n_cmp++; if (wr_allow !== 1'b0 || occupancy !== 3'd4) begin n_bad++; $display("FAIL stall_wait: got allow=%b occ=%0d want 0/4", wr_allow, occupancy); end
        n_cmp++; if (base_addr !== 16'h0100) begin n_bad++; $display("FAIL stall_base: got %h want 0100", base_addr); end
        write_words(1);
        n_cmp++; if (err !== 1'b1 || wr_allow !== 1'b0) begin n_bad++; $display("FAIL stall_wr_err: got err=%b allow=%b want 1/0", err, wr_allow); end
        release_one();
        n_cmp++; if (wr_allow !== 1'b1 || occupancy !== 3'd3) begin n_bad++; $display("FAIL stall_release: got allow=%b occ=%0d want 1/3", wr_allow, occupancy); end
    endtask

    task automatic test_flush();
        write_words(3);
        cfg_flush = 1'b1; tick(); cfg_flush = 1'b0;
        n_cmp++; if (batch_done !== 1'b1 || done_len !== 4'd3 || done_slot !== 2'd0) begin n_bad++; $display("FAIL flush_partial: got done=%b len=%0d slot=%0d want 1/3/0", batch_done, done_len, done_slot); end
        release_one();
        n_cmp++; if (wr_allow !== 1'b1 || occupancy !== 3'd3 || base_addr !== 16'h0108) begin n_bad++; $display("FAIL flush_coincide: got allow=%b occ=%0d base=%h want 1/3/0108", wr_allow, occupancy, base_addr); end
        cfg_flush = 1'b1; tick(); cfg_flush = 1'b0;
        n_cmp++; if (batch_done !== 1'b0 || wr_allow !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got done=%b allow=%b want 0/1", batch_done, wr_allow); end
        wr_done = 1'b1; cfg_flush = 1'b1; tick(); wr_done = 1'b0; cfg_flush = 1'b0;
        n_cmp++; if (batch_done !== 1'b1 || done_len !== 4'd1 || done_slot !== 2'd1) begin n_bad++; $display("FAIL flush_same_cycle: got done=%b len=%0d slot=%0d want 1/1/1", batch_done, done_len, done_slot); end
        tick();
        n_cmp++; if (wr_allow !== 1'b0 || occupancy !== 3'd4 || base_addr !== 16'h0110) begin n_bad++; $display("FAIL flush_wait: got allow=%b occ=%0d base=%h want 0/4/0110", wr_allow, occupancy, base_addr); end
    endtask

    task automatic test_abort_errors();
        release_one();
        write_words(2);
        abort();
        n_cmp++; if (batch_done !== 1'b0 || wr_allow !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL abort_idle: got done=%b allow=%b occ=%0d want 0/0/0", batch_done, wr_allow, occupancy); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL abort_err_kept: got %b want 1", err); end
        tick();
        n_cmp++; if (batch_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_late_done: got %b want 0", batch_done); end
        start(16'h0100);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL start_clears_err: got %b want 0", err); end
        release_one();
        n_cmp++; if (err !== 1'b1 || occupancy !== 3'd0) begin n_bad++; $display("FAIL release_underflow: got err=%b occ=%0d want 1/0", err, occupancy); end
    endtask

    task automatic test_wrap();
        abort();
        start(16'hFFF0);
        n_cmp++; if (base_addr !== 16'hFFF0) begin n_bad++; $display("FAIL wrap_base0: got %h want fff0", base_addr); end
        write_words(8); tick();
        n_cmp++; if (base_addr !== 16'hFFF8) begin n_bad++; $display("FAIL wrap_base1: got %h want fff8", base_addr); end
        write_words(8); tick();
        n_cmp++; if (base_addr !== 16'h0000 || occupancy !== 3'd2) begin n_bad++; $display("FAIL wrap_base2: got base=%h occ=%0d want 0000/2", base_addr, occupancy); end
    endtask

    task automatic test_idle_close();
        int early = 0;
        abort();
        start(16'h0000);
        write_words(2);
`ifdef RAM_WR_SCHED_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            if (batch_done === 1'b1) early++;
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL timeout_early: got %0d early closes want 0", early); end
        tick();
        n_cmp++; if (batch_done !== 1'b1 || done_len !== 4'd2) begin n_bad++; $display("FAIL timeout_close: got done=%b len=%0d want 1/2", batch_done, done_len); end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (batch_done === 1'b1) early++;
        end
        n_cmp++; if (early != 0 || wr_allow !== 1'b1) begin n_bad++; $display("FAIL idle_no_close: got %0d closes allow=%b want 0/1", early, wr_allow); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_flush();
        test_abort_errors();
        test_wrap();
        test_idle_close();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
